alu_sequencer: RTL
==================

// Module: alu_sequencer
// PURPOSE
//  Multi-cycle control FSM that sequences the shared ALU (Temp/G registers) and register file on a
//  single bus. Latches one 10-bit instruction per Exec request, then drives Rout/Rin, Ain, Gin, Gout,
//  FN and Extern over 1-3 execute cycles. Sits between instruction source and datapath.
// PARAMETERS
//  NREG   4    number of general registers; Rx/Ry fields are log2(NREG) bits (2 at default)
// PORTS
//  CLKb    in   1     system clock; all state updates on negedge CLKb (same edge as ALU)
//  Rst     in   1     asynchronous, active-high reset
//  INSTR   in   10    instruction: [9:6]=FN, [5:4]=Rx (dest/OP), [3:2]=Ry (src/Temp), [1:0] ignored
//  Exec    in   1     start request; sampled only in IDLE
//  Rin     out  NREG  one-hot register write enable (Rin[Rx])
//  Rout    out  NREG  one-hot register bus drive enable
//  Ain     out  1     ALU Temp load from bus
//  Gin     out  1     ALU G load from ALU result
//  Gout    out  1     ALU G drive onto bus
//  FN      out  4     ALU function select
//  Extern  out  1     external data drives bus (load instruction)
//  Busy    out  1     high in every state except IDLE
//  Done    out  1     one-cycle pulse in final execute state
//  Err     out  1     sticky: illegal FN (4'b1100-4'b1111) seen; cleared by Rst or next accepted Exec
// BEHAVIOUR
//  - Reset (async, any state, incl. mid-instruction): state=IDLE, IR=0, Err=0; all outputs 0, FN=0.
//  - States: IDLE, T1, T2, T3. Outputs are Moore-decoded from state + latched IR (no Exec->output path).
//  - IDLE: Exec=1 at negedge -> IR<=INSTR, Err<=0, go T1. Exec=0 -> stay. Busy=0.
//  - Exec while Busy is ignored; INSTR changes after acceptance have no effect.
//  - FN output = IR[9:6] in T2 only; 0 otherwise.
//  - LOAD (0000): T1: Extern=1, Rin[Rx]=1, Done=1 -> IDLE. Latency 1 execute cycle.
//  - ILLEGAL (1100-1111): T1: Err<=1, Done=1, no Rin/Ain/Gin/Gout -> IDLE.
//  - All others (0001-1011): 3 execute cycles:
//      T1: Rout[Ry]=1, Ain=1                    (Temp <= Ry)
//      T2: Rout[Rx]=1, Gin=1, FN=IR[9:6]        (G <= Rx op Temp)
//      T3: Gout=1, Rin[Rx]=1, Done=1 -> IDLE    (Rx <= G)
//    Result Rx <= f(Rx, Ry): copy=Ry, add=Rx+Ry, sub=Rx-Ry, inv=-Ry, flip=~Ry, and/or/xor,
//    shl/shr/asr act on Rx. All arithmetic mod 2^10; no flags.
//  - Rx==Ry legal: T1 and T2 drive the same register; result as above with both operands equal.
//  - Exactly one bus driver per cycle (Rout one-hot, Gout, Extern mutually exclusive); zero in IDLE.
//  - Back-to-back: Exec held high -> new instruction accepted in the IDLE cycle after Done
//    (one idle cycle between instructions minimum).
//  - Rx/Ry index >= NREG (NREG not power of 2): treated as illegal -> Err path.
// TESTING
//  1 Rst asserted mid-T2 of add -> same-cycle: all outputs 0, Busy=0; next Exec runs from T1 cleanly.
//  2 INSTR=10'b0000_01_00_00, Exec pulse, Extern bus=10'h155 -> 1 cycle Extern=1,Rin=0010,Done; R1=0x155.
//  3 R1=0x00A, R2=0x003, INSTR=0011_01_10_00 (sub R1,R2) -> T1 Rout=0100+Ain, T2 Rout=0010+Gin+FN=0011,
//    T3 Gout+Rin=0010+Done; R1=0x007. Repeat with R2=0x00B -> R1=0x3FF (wrap).
//  4 R0=0x201, INSTR=1011_00_00_00 (asr) -> R0=0x300; INSTR=1010 (shr) -> R0=0x100.
//  5 INSTR=1110_..., Exec -> Err=1, Done in T1, no Rin/Gout; next legal Exec clears Err.
//  6 Exec held high, INSTR toggled during T1-T3 -> latched instruction unchanged; second accepted
//    after one IDLE cycle; assert single bus driver every cycle throughout.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// Instruction/control bundle between the instruction source and the ALU sequencer.
// The master side issues instructions. The slave side is the sequencer, which returns
// datapath controls and status.
interface alu_sequencer_if #(
   parameter int NREG = 4
);
   logic [9:0]      INSTR;
   logic            Exec;
   logic [NREG-1:0] Rin;
   logic [NREG-1:0] Rout;
   logic            Ain;
   logic            Gin;
   logic            Gout;
   logic [3:0]      FN;
   logic            Extern;
   logic            Busy;
   logic            Done;
   logic            Err;

   modport master (
      output INSTR, Exec,
      input  Rin, Rout, Ain, Gin, Gout, FN, Extern, Busy, Done, Err
   );

   modport slave (
      input  INSTR, Exec,
      output Rin, Rout, Ain, Gin, Gout, FN, Extern, Busy, Done, Err
   );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle control FSM for a shared-bus ALU datapath.
// One instruction is latched per accepted Exec. The FSM then runs 1 or 3 execute states.
// All state advances on the falling edge of CLKb, which is the same edge the ALU uses.
// Every output is Moore-decoded from the state and the latched instruction.
module alu_sequencer #(
   parameter int NREG = 4
) (
   input  logic             CLKb,
   input  logic             Rst,
   alu_sequencer_if.slave   bus_if
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_T1   = 2'd1,
      S_T2   = 2'd2,
      S_T3   = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [9:0]  ir_q, ir_d;
   logic        err_q, err_d;

   logic [3:0]      fn;
   logic [1:0]      rx;
   logic [1:0]      ry;
   logic [3:0]      reg_ok;
   logic [NREG-1:0] rx_hot;
   logic [NREG-1:0] ry_hot;
   logic            is_load;
   logic            is_illegal;

   logic [NREG-1:0] rin_o, rout_o;
   logic            ain_o, gin_o, gout_o, extern_o, busy_o, done_o;
   logic [3:0]      fn_o;

   // The two low instruction bits are carried in IR but carry no meaning.
   logic unused_ir;
   assign unused_ir = ^ir_q[1:0];

   assign fn = ir_q[9:6];
   assign rx = ir_q[5:4];
   assign ry = ir_q[3:2];

   // A 2-bit field can name a register that does not exist when NREG is below 4.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_reg_ok
         assign reg_ok[gi] = (gi < NREG);
      end
      for (gi = 0; gi < NREG; gi++) begin : g_hot
         assign rx_hot[gi] = (32'(rx) == gi);
         assign ry_hot[gi] = (32'(ry) == gi);
      end
   endgenerate

   assign is_load    = (fn == 4'b0000);
   assign is_illegal = (fn >= 4'b1100) || !reg_ok[rx] || !reg_ok[ry];

   // State, instruction and sticky error registers update on the falling clock edge.
   // Reset is asynchronous.
   always_ff @(negedge CLKb or posedge Rst) begin
      if (Rst) begin
         state_q <= S_IDLE;
         ir_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic.
   // An instruction is accepted only in IDLE. Illegal and LOAD instructions finish in T1.
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (bus_if.Exec) begin
               ir_d    = bus_if.INSTR;
               err_d   = 1'b0;
               state_d = S_T1;
            end
         end
         S_T1: begin
            if (is_illegal) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else if (is_load) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_T2;
            end
         end
         S_T2:    state_d = S_T3;
         S_T3:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Moore output decode.
   // At most one bus driver is active per state: Rout, Gout or Extern.
   always_comb begin
      rin_o    = '0;
      rout_o   = '0;
      ain_o    = 1'b0;
      gin_o    = 1'b0;
      gout_o   = 1'b0;
      extern_o = 1'b0;
      done_o   = 1'b0;
      fn_o     = 4'b0000;
      busy_o   = (state_q != S_IDLE);
      case (state_q)
         S_T1: begin
            if (is_illegal) begin
               done_o = 1'b1;
            end else if (is_load) begin
               extern_o = 1'b1;
               rin_o    = rx_hot;
               done_o   = 1'b1;
            end else begin
               rout_o = ry_hot;
               ain_o  = 1'b1;
            end
         end
         S_T2: begin
            rout_o = rx_hot;
            gin_o  = 1'b1;
            fn_o   = fn;
         end
         S_T3: begin
            gout_o = 1'b1;
            rin_o  = rx_hot;
            done_o = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus_if.Rin    = rin_o;
   assign bus_if.Rout   = rout_o;
   assign bus_if.Ain    = ain_o;
   assign bus_if.Gin    = gin_o;
   assign bus_if.Gout   = gout_o;
   assign bus_if.FN     = fn_o;
   assign bus_if.Extern = extern_o;
   assign bus_if.Busy   = busy_o;
   assign bus_if.Done   = done_o;
   assign bus_if.Err    = err_q;

endmodule
